rv32m_seq_ctrl: RTL and testbench

//  Iterative sequencer for the RV32M multiply/divide unit that serves the EX stage.

---
 rtl/rv32m_seq_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_rv32m_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_seq_ctrl.sv
// Iterative radix-2 multiply/divide sequencer for the RV32M extension in EX.
// Optional result reuse between paired ops is enabled by defining RV32M_RESULT_REUSE_EN.
module rv32m_seq_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_en,
   input  logic            i_kill,
   input  logic [2:0]      i_f3,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic [XLEN-1:0] o_res,
   output logic            o_valid,
   output logic            o_stall,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;

   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] op_reg;
   logic [XLEN-1:0] acc_hi;
   logic [XLEN-1:0] acc_lo;
   logic            res_neg;
   logic            rem_neg;

   logic            in_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b;

   // signedness of each operand: MULH both, MULHSU rs1 only, DIV/REM both
   assign in_div   = i_f3[2];
   assign sgn_a    = (i_f3 == 3'b001) | (i_f3 == 3'b010) | (i_f3[2] & ~i_f3[0]);
   assign sgn_b    = (i_f3 == 3'b001) | (i_f3[2] & ~i_f3[0]);
   assign neg_a    = sgn_a & i_rs1[XLEN-1];
   assign neg_b    = sgn_b & i_rs2[XLEN-1];
   assign mag_a    = neg_a ? -i_rs1 : i_rs1;
   assign mag_b    = neg_b ? -i_rs2 : i_rs2;
   assign div_zero = in_div & (i_rs2 == '0);
   assign div_ovf  = in_div & ~i_f3[0] & (i_rs1 == MIN_NEG) & (i_rs2 == '1);

   logic [XLEN:0]     mul_sum, div_shift, div_trial;
   logic [XLEN-1:0]   acc_hi_n, acc_lo_n;
   logic [2*XLEN-1:0] prod_mag, prod;
   logic [XLEN-1:0]   quo, rem, calc_hi, calc_lo;

   // One radix-2 step; a non-negative trial remainder always fits back into XLEN bits
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_reg} : '0);
      div_shift = {acc_hi, acc_lo[XLEN-1]};
      div_trial = div_shift - {1'b0, op_reg};
      acc_hi_n  = mul_sum[XLEN:1];
      acc_lo_n  = {mul_sum[0], acc_lo[XLEN-1:1]};
      if (f3_q[2]) begin
         if (!div_trial[XLEN]) begin
            acc_hi_n = div_trial[XLEN-1:0];
            acc_lo_n = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            acc_hi_n = div_shift[XLEN-1:0];
            acc_lo_n = {acc_lo[XLEN-2:0], 1'b0};
         end
      end
      prod_mag = {acc_hi_n, acc_lo_n};
      prod     = res_neg ? -prod_mag : prod_mag;
      quo      = res_neg ? -acc_lo_n : acc_lo_n;
      rem      = rem_neg ? -acc_hi_n : acc_hi_n;
      calc_hi  = f3_q[2] ? rem : prod[2*XLEN-1:XLEN];
      calc_lo  = f3_q[2] ? quo : prod[XLEN-1:0];
   end

`ifdef RV32M_RESULT_REUSE_EN
   logic            st_valid;
   logic [1:0]      st_cls;
   logic [XLEN-1:0] st_rs1, st_rs2, st_hi, st_lo, cur_rs1, cur_rs2;
   logic            hit;

   assign hit = st_valid & (i_rs1 == st_rs1) & (i_rs2 == st_rs2) &
                (((i_f3 == 3'b000) & ~st_cls[1]) |
                 (i_f3[2] & st_cls[1] & (i_f3[0] == st_cls[0])));
`endif

   logic            start, step, finish;
   logic [XLEN-1:0] fin_hi, fin_lo, res_sel;
   logic [2:0]      fin_f3;

   // Next state plus the full 2-word result whenever an op finishes this cycle
   always_comb begin
      state_n = state;
      start   = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      fin_hi  = '0;
      fin_lo  = '0;
      fin_f3  = f3_q;
      case (state)
         IDLE: begin
            if (i_en & ~i_kill) begin
               fin_f3 = i_f3;
`ifdef RV32M_RESULT_REUSE_EN
               if (hit) begin
                  finish  = 1'b1;
                  fin_hi  = st_hi;
                  fin_lo  = st_lo;
                  state_n = DONE;
               end else
`endif
               if (div_zero) begin
                  finish  = 1'b1;
                  fin_hi  = i_rs1;
                  fin_lo  = '1;
                  state_n = DONE;
               end else if (div_ovf) begin
                  finish  = 1'b1;
                  fin_hi  = '0;
                  fin_lo  = MIN_NEG;
                  state_n = DONE;
               end else begin
                  start   = 1'b1;
                  state_n = CALC;
               end
            end
         end
         CALC: begin
            if (i_kill | ~i_en) begin
               state_n = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CNT_LAST) begin
                  finish  = 1'b1;
                  fin_hi  = calc_hi;
                  fin_lo  = calc_lo;
                  state_n = DONE;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      res_sel = ((fin_f3 == 3'b000) || (fin_f3[2:1] == 2'b10)) ? fin_lo : fin_hi;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         cnt     <= '0;
         f3_q    <= '0;
         op_reg  <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         res_neg <= 1'b0;
         rem_neg <= 1'b0;
         o_res   <= '0;
         o_valid <= 1'b0;
      end else begin
         state   <= state_n;
         o_valid <= finish;
         if (finish) o_res <= res_sel;
         if (start) begin
            cnt     <= '0;
            f3_q    <= i_f3;
            op_reg  <= in_div ? mag_b : mag_a;
            acc_hi  <= '0;
            acc_lo  <= in_div ? mag_a : mag_b;
            res_neg <= neg_a ^ neg_b;
            rem_neg <= neg_a;
         end else if (step) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= acc_hi_n;
            acc_lo <= acc_lo_n;
         end
      end
   end

`ifdef RV32M_RESULT_REUSE_EN
   // Every finished op refreshes the entry; a flush drops it
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_valid <= 1'b0;
         st_cls   <= '0;
         st_rs1   <= '0;
         st_rs2   <= '0;
         st_hi    <= '0;
         st_lo    <= '0;
         cur_rs1  <= '0;
         cur_rs2  <= '0;
      end else begin
         if (start) begin
            cur_rs1 <= i_rs1;
            cur_rs2 <= i_rs2;
         end
         if (finish) begin
            st_valid <= 1'b1;
            st_cls   <= {fin_f3[2], fin_f3[0]};
            st_rs1   <= (state == IDLE) ? i_rs1 : cur_rs1;
            st_rs2   <= (state == IDLE) ? i_rs2 : cur_rs2;
            st_hi    <= fin_hi;
            st_lo    <= fin_lo;
         end else if (i_kill) begin
            st_valid <= 1'b0;
         end
      end
   end
`endif

   assign o_stall = i_en & ~o_valid;
   assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_rv32m_seq_ctrl.sv
// Randomized self-checking bench for rv32m_seq_ctrl against a 64-bit arithmetic reference model.
// Honours RV32M_RESULT_REUSE_EN when the design is built with it.
module tb_rv32m_seq_ctrl;

   logic        i_clk  = 1'b0;
   logic        i_rst  = 1'b1;
   logic        i_en   = 1'b0;
   logic        i_kill = 1'b0;
   logic [2:0]  i_f3   = '0;
   logic [31:0] i_rs1  = '0;
   logic [31:0] i_rs2  = '0;
   logic [31:0] o_res;
   logic        o_valid, o_stall, o_busy;

   int  cyc = 0;
   int  errors = 0;
   int  checks = 0;
   bit  in_reset = 1'b1;
   int  op_start = -10;
   int  op_valid_at = -1;
   int  op_end = -10;
   logic [31:0] exp_res = '0;

   bit          rv_valid = 1'b0;
   logic [31:0] rv_a = '0, rv_b = '0;
   logic [2:0]  rv_f3 = '0;

`ifdef RV32M_RESULT_REUSE_EN
   localparam int REUSE_LAT = 1;
`else
   localparam int REUSE_LAT = 33;
`endif

   rv32m_seq_ctrl #(.XLEN(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_kill(i_kill), .i_f3(i_f3),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .o_res(o_res), .o_valid(o_valid),
      .o_stall(o_stall), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Architectural result of an RV32M op computed with wide arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      int qa, qb;
      bit ovf;
      sa  = (f3 == 3'b000 || f3 == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
      sb  = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
      p   = sa * sb;
      qa  = a;
      qb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'b000:  return p[31:0];
         3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(qa / qb);
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(qa % qb);
         3'b111:  return (b == 0) ? a : a % b;
         default: return p[63:32];
      endcase
   endfunction

   function automatic bit reuse_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef RV32M_RESULT_REUSE_EN
      if (!rv_valid || a != rv_a || b != rv_b) return 1'b0;
      if (f3 == 3'b000 && rv_f3 inside {3'b000, 3'b001, 3'b010, 3'b011}) return 1'b1;
      if (f3 inside {3'b100, 3'b110} && rv_f3 inside {3'b100, 3'b110}) return 1'b1;
      if (f3 inside {3'b101, 3'b111} && rv_f3 inside {3'b101, 3'b111}) return 1'b1;
      return 1'b0;
`else
      return (f3 == 3'b111) && (a == 32'h1) && (b == 32'h1) && rv_valid && 1'b0;
`endif
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (reuse_hit(f3, a, b)) return 1;
      if (f3[2] && b == 0) return 1;
      if (f3 inside {3'b100, 3'b110} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Compare process: all outputs every cycle against the current expectation
   always @(negedge i_clk) begin
      bit ev, eb;
      if (in_reset) begin
         check_output("reset_valid", {31'b0, o_valid}, 32'h0);
         check_output("reset_busy",  {31'b0, o_busy},  32'h0);
         check_output("reset_res",   o_res,            32'h0);
      end else begin
         ev = (cyc == op_valid_at);
         eb = (cyc > op_start) && (cyc <= op_end);
         check_output("valid", {31'b0, o_valid}, {31'b0, ev});
         check_output("busy",  {31'b0, o_busy},  {31'b0, eb});
         check_output("stall", {31'b0, o_stall}, {31'b0, i_en & ~ev});
         if (ev) check_output("res", o_res, exp_res);
      end
   end

   // abort_kind: 0 none, 1 kill, 2 i_en drop, 3 reset, applied at cycle abort_at of the op
   task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input int abort_kind, input int abort_at,
                                 input bit has_pin, input logic [31:0] pin_res, input int pin_lat);
      int lat, kind;
      logic [31:0] r;
      lat  = ref_lat(f3, a, b);
      r    = ref_res(f3, a, b);
      kind = (abort_at >= lat) ? 0 : abort_kind;
      if (has_pin) check_output("model_res_pin", r, pin_res);
      if (pin_lat > 0) check_output("model_lat_pin", 32'(lat), 32'(pin_lat));
      i_en = 1'b1; i_kill = 1'b0; i_f3 = f3; i_rs1 = a; i_rs2 = b;
      exp_res     = r;
      op_start    = cyc;
      op_valid_at = (kind != 0) ? -1 : cyc + lat;
      op_end      = (kind != 0) ? cyc + abort_at : cyc + lat;
      for (int k = 1; k <= lat; k++) begin
         @(posedge i_clk); #1;
         if (kind != 0 && k == abort_at) begin
            case (kind)
               1: begin i_kill = 1'b1; rv_valid = 1'b0; end
               2: i_en = 1'b0;
               default: begin
                  i_rst = 1'b1; in_reset = 1'b1; i_en = 1'b0; rv_valid = 1'b0;
                  op_start = -10; op_valid_at = -1; op_end = -10;
               end
            endcase
            @(posedge i_clk); #1;
            i_kill = 1'b0; i_en = 1'b0; i_rst = 1'b0; in_reset = 1'b0;
            return;
         end
         i_rs1 = $urandom(); i_rs2 = $urandom(); i_f3 = 3'($urandom_range(0, 7));
      end
      rv_valid = 1'b1; rv_a = a; rv_b = b; rv_f3 = f3;
      @(posedge i_clk); #1;
      i_en = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      logic [31:0] la, lb, a, b;
      int kind;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0; in_reset = 1'b0;
      @(posedge i_clk); #1;

      apply_stimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFE, 33);
      apply_stimulus(3'b000, -32'sd7, 32'd3, 0, 0, 1, 32'hFFFF_FFEB, 0);
      apply_stimulus(3'b001, -32'sd7, 32'd3, 0, 0, 1, 32'hFFFF_FFFF, 0);
      apply_stimulus(3'b010, 32'hFFFF_FFFF, 32'd2, 0, 0, 1, 32'hFFFF_FFFF, 0);
      apply_stimulus(3'b100, -32'sd20, 32'd6, 0, 0, 1, 32'hFFFF_FFFD, 0);
      apply_stimulus(3'b110, -32'sd20, 32'd6, 0, 0, 1, 32'hFFFF_FFFE, 0);
      apply_stimulus(3'b101, 32'd20, 32'd6, 0, 0, 1, 32'd3, 0);
      apply_stimulus(3'b111, 32'd20, 32'd6, 0, 0, 1, 32'd2, 0);
      apply_stimulus(3'b101, 32'd5, 32'd0, 0, 0, 1, 32'hFFFF_FFFF, 1);
      apply_stimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h0, 1);
      apply_stimulus(3'b100, 32'd1000, 32'd7, 3, 10, 1, 32'd142, 33);
      apply_stimulus(3'b100, 32'd1000, 32'd7, 1, 12, 1, 32'd142, 33);
      apply_stimulus(3'b000, 32'd1234, 32'd5678, 2, 5, 0, 32'h0, 0);

      apply_stimulus(3'b100, 32'd100, 32'd7, 0, 0, 1, 32'd14, 33);
      apply_stimulus(3'b110, 32'd100, 32'd7, 0, 0, 1, 32'd2, REUSE_LAT);
      i_kill = 1'b1; rv_valid = 1'b0;
      @(posedge i_clk); #1 i_kill = 1'b0;
      apply_stimulus(3'b110, 32'd100, 32'd7, 0, 0, 1, 32'd2, 33);
      apply_stimulus(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 32'h0, 0);
      apply_stimulus(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 32'h0, REUSE_LAT);

      // Kill together with enable in IDLE must not start anything
      i_en = 1'b1; i_kill = 1'b1; i_f3 = 3'b101; i_rs1 = 32'd9; i_rs2 = 32'd3; rv_valid = 1'b0;
      @(posedge i_clk); #1 i_en = 1'b0; i_kill = 1'b0;
      @(posedge i_clk); #1;

      la = 32'd1; lb = 32'd1;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            a = la; b = lb;
         end else begin
            a = pick(); b = pick();
         end
         kind = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
         apply_stimulus(3'($urandom_range(0, 7)), a, b, kind, $urandom_range(1, 32), 0, 32'h0, 0);
         la = a; lb = b;
         repeat ($urandom_range(0, 2)) begin
            @(posedge i_clk); #1;
         end
      end

      @(posedge i_clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
